counter_sequencer: RTL and testbench

Run/pause/clear controller for the 16-bit counter datapath on the Tang Nano 9K board. Debounces `btn1` and classifies short and long presses. Runs an IDLE/RUN/PAUSE state machine. Produces the counter's single-cycle count-enable `tick` at a switch-selected rate, plus a one-cycle `clr` and a direction bit. Sits between the board inputs and the counter/display datapath.

---
 rtl/counter_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_counter_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// ----------------------------------------------------------------------------
// counter_sequencer
//
// Run/pause/clear controller for the 16-bit counter datapath. Debounces the
// active-low push button, classifies short and long presses, runs an
// IDLE/RUN/PAUSE state machine and produces a rate-selectable single-cycle
// count enable.
//
// Ports:
//   clk     in   1  board clock
//   rst     in   1  asynchronous active-low reset
//   btn1    in   1  raw push button, active-low, asynchronous to clk
//   switch  in   8  [7] direction (1 = down), [3:0] rate code R, [6:4] unused
//   tick    out  1  one-cycle count enable, period (R+1)*TICK_DIV in RUN
//   clr     out  1  one-cycle synchronous clear after a long press
//   dir     out  1  registered copy of switch[7]
//   state   out  2  00 IDLE, 01 RUN, 10 PAUSE
// ----------------------------------------------------------------------------
module counter_sequencer #(
    parameter int unsigned CLKFREQ         = 27_000_000,
    parameter int unsigned TICK_DIV        = CLKFREQ / 100,
    parameter int unsigned DEBOUNCE_CYCLES = CLKFREQ / 100,
    parameter int unsigned LONG_CYCLES     = CLKFREQ
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn1,
    input  logic [7:0] switch,
    output logic       tick,
    output logic       clr,
    output logic       dir,
    output logic [1:0] state
);

    // ------------------------------------------------------------------------
    // Counter widths and terminal values
    // ------------------------------------------------------------------------
    localparam int unsigned BaseW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DbcW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HoldW = $clog2(LONG_CYCLES + 1);

    localparam logic [BaseW-1:0] BaseLast = BaseW'(TICK_DIV - 1);
    localparam logic [DbcW-1:0]  DbcLast  = DbcW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldMax  = HoldW'(LONG_CYCLES);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic             r_s1;
    logic             r_s2;
    logic             r_db_level;
    logic [DbcW-1:0]  r_dbc;
    logic [HoldW-1:0] r_hold;
    logic             r_long;
    state_t           r_state;
    logic [BaseW-1:0] r_base;
    logic [3:0]       r_rc;
    logic             r_tick;
    logic             r_clr;
    logic             r_dir;

    // ------------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------------
    logic             w_db_level_d;
    logic [DbcW-1:0]  w_dbc_d;
    logic             w_db_update;
    logic             w_release;
    logic             w_long_evt;
    logic [HoldW-1:0] w_hold_d;
    logic             w_long_d;
    state_t           w_state_d;
    logic [BaseW-1:0] w_base_d;
    logic [3:0]       w_rc_d;
    logic             w_wrap;
    logic             w_tick_d;
    logic [3:0]       w_rate;
    logic             w_unused;

    assign w_rate   = switch[3:0];
    assign w_unused = ^switch[6:4];

    // ------------------------------------------------------------------------
    // Debouncer: a new level is accepted only after DEBOUNCE_CYCLES
    // consecutive samples that disagree with the current level.
    // ------------------------------------------------------------------------
    always_comb begin
        w_db_level_d = r_db_level;
        w_dbc_d      = r_dbc;
        w_db_update  = 1'b0;
        if (r_s2 == r_db_level) begin
            w_dbc_d = '0;
        end else if (r_dbc == DbcLast) begin
            w_db_level_d = r_s2;
            w_dbc_d      = '0;
            w_db_update  = 1'b1;
        end else begin
            w_dbc_d = r_dbc + 1'b1;
        end
    end

    // Release is the cycle in which the debounced level is about to rise.
    assign w_release = w_db_update & r_s2;

    // ------------------------------------------------------------------------
    // Hold counter and long-press flag
    // ------------------------------------------------------------------------
    assign w_long_evt = ~r_db_level && (r_hold == HoldLast);

    always_comb begin
        w_hold_d = r_hold;
        w_long_d = r_long;
        if (~r_db_level && (r_hold != HoldMax)) begin
            w_hold_d = r_hold + 1'b1;
        end
        if (w_long_evt) begin
            w_long_d = 1'b1;
        end
        // A release always ends the hold, even if it coincides with saturation.
        if (w_release) begin
            w_hold_d = '0;
            w_long_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Run/pause state machine
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state;
        if (w_long_evt) begin
            w_state_d = StIdle;
        end else if (w_release && !r_long) begin
            unique case (r_state)
                StIdle:  w_state_d = StRun;
                StRun:   w_state_d = StPause;
                StPause: w_state_d = StRun;
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // ------------------------------------------------------------------------
    // Prescaler: base counter wraps every TICK_DIV cycles, rate counter wraps
    // every R+1 base pulses. Counters advance in RUN, hold in PAUSE and are
    // forced to zero whenever the machine is (or is about to be) IDLE.
    // ------------------------------------------------------------------------
    always_comb begin
        w_base_d = r_base;
        w_rc_d   = r_rc;
        w_wrap   = 1'b0;
        unique case (r_state)
            StRun: begin
                if (r_base == BaseLast) begin
                    w_base_d = '0;
                    if (r_rc == w_rate) begin
                        w_rc_d = '0;
                        w_wrap = 1'b1;
                    end else if (r_rc > w_rate) begin
                        // R was lowered below the current count: restart silently.
                        w_rc_d = '0;
                    end else begin
                        w_rc_d = r_rc + 4'd1;
                    end
                end else begin
                    w_base_d = r_base + 1'b1;
                end
            end
            StPause: begin
                w_base_d = r_base;
                w_rc_d   = r_rc;
            end
            default: begin
                w_base_d = '0;
                w_rc_d   = '0;
            end
        endcase
        if (w_state_d == StIdle) begin
            w_base_d = '0;
            w_rc_d   = '0;
        end
    end

    // A wrap in the cycle that leaves RUN is dropped so tick never lands
    // outside RUN.
    assign w_tick_d = w_wrap && (w_state_d == StRun);

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1       <= 1'b1;
            r_s2       <= 1'b1;
            r_db_level <= 1'b1;
            r_dbc      <= '0;
            r_hold     <= '0;
            r_long     <= 1'b0;
            r_base     <= '0;
            r_rc       <= '0;
            r_tick     <= 1'b0;
            r_clr      <= 1'b0;
            r_dir      <= 1'b0;
        end else begin
            r_s1       <= btn1;
            r_s2       <= r_s1;
            r_db_level <= w_db_level_d;
            r_dbc      <= w_dbc_d;
            r_hold     <= w_hold_d;
            r_long     <= w_long_d;
            r_base     <= w_base_d;
            r_rc       <= w_rc_d;
            r_tick     <= w_tick_d;
            r_clr      <= w_long_evt;
            r_dir      <= switch[7];
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign tick  = r_tick;
    assign clr   = r_clr;
    assign dir   = r_dir;
    assign state = r_state;

endmodule

// File: tb/tb_counter_sequencer.sv
// ----------------------------------------------------------------------------
// tb_counter_sequencer
//
// Self-checking bench for counter_sequencer with TICK_DIV=4,
// DEBOUNCE_CYCLES=3, LONG_CYCLES=20. A table of button/switch steps checks
// state, dir and clr; hand-written sequences cover tick timing, pause/resume
// phase, long-press clear and asynchronous reset.
// ----------------------------------------------------------------------------
module tb_counter_sequencer;

    logic       clk;
    logic       rst;
    logic       btn1;
    logic [7:0] switch;
    logic       tick;
    logic       clr;
    logic       dir;
    logic [1:0] state;

    int tests;
    int fails;

    counter_sequencer #(
        .CLKFREQ        (400),
        .TICK_DIV       (4),
        .DEBOUNCE_CYCLES(3),
        .LONG_CYCLES    (20)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .btn1  (btn1),
        .switch(switch),
        .tick  (tick),
        .clr   (clr),
        .dir   (dir),
        .state (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       btn;
        logic [7:0] sw;
        int         cyc;
        logic [1:0] st;
        logic       dr;
        logic       cl;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Cycles (negedges) until tick is seen, or -1 if it never comes.
    task automatic wait_tick(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (tick === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_state(input logic [1:0] s, input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (state === s) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic short_press();
        btn1 = 1'b0;
        repeat (4) @(negedge clk);
        btn1 = 1'b1;
    endtask

    int n;
    int cnt;
    int tick_j;
    int clr_n;
    int clr_j;
    int late_ticks;
    bit done;

    initial begin
        tests  = 0;
        fails  = 0;
        rst    = 1'b1;
        btn1   = 1'b1;
        switch = 8'h00;

        // ---------------- reset then idle ----------------
        #1 rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("reset_state", int'(state), 0);
            check("reset_tick", int'(tick), 0);
            check("reset_clr", int'(clr), 0);
        end
        rst = 1'b1;
        repeat (100) begin
            @(negedge clk);
            check("idle_state", int'(state), 0);
            check("idle_tick", int'(tick), 0);
            check("idle_clr", int'(clr), 0);
        end

        // ---------------- table-driven steps ----------------
        vecs.push_back('{1'b1, 8'h00, 3, 2'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h80, 1, 2'd0, 1'b1, 1'b0});  // dir latency 1
        vecs.push_back('{1'b1, 8'h00, 1, 2'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 8, 2'd0, 1'b0, 1'b0});  // press: no change
        vecs.push_back('{1'b1, 8'h00, 8, 2'd1, 1'b0, 1'b0});  // IDLE -> RUN
        vecs.push_back('{1'b0, 8'h00, 4, 2'd1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h00, 8, 2'd2, 1'b0, 1'b0});  // RUN -> PAUSE
        vecs.push_back('{1'b0, 8'h00, 4, 2'd2, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h00, 8, 2'd1, 1'b0, 1'b0});  // PAUSE -> RUN
        vecs.push_back('{1'b0, 8'h00, 40, 2'd0, 1'b0, 1'b0}); // long -> IDLE
        vecs.push_back('{1'b1, 8'h00, 10, 2'd0, 1'b0, 1'b0}); // long release: none
        for (int i = 0; i < 10; i++) begin                     // bounce
            vecs.push_back('{(i % 2 == 1), 8'h00, 2, 2'd0, 1'b0, 1'b0});
        end
        vecs.push_back('{1'b1, 8'h00, 10, 2'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h80, 2, 2'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 8'h00, 2, 2'd0, 1'b0, 1'b0});

        foreach (vecs[i]) begin
            btn1   = vecs[i].btn;
            switch = vecs[i].sw;
            repeat (vecs[i].cyc) @(negedge clk);
            check($sformatf("vec%0d_state", i), int'(state), int'(vecs[i].st));
            check($sformatf("vec%0d_dir", i), int'(dir), int'(vecs[i].dr));
            check($sformatf("vec%0d_clr", i), int'(clr), int'(vecs[i].cl));
        end

        // ---------------- tick timing, R=0 then R=2 ----------------
        switch = 8'h00;
        short_press();
        wait_state(2'd1, 20, n);
        check("release_to_run", n, 5);
        wait_tick(20, n);
        check("first_tick_r0", n, 4);
        wait_tick(20, n);
        check("period_r0_a", n, 4);
        wait_tick(20, n);
        check("period_r0_b", n, 4);
        switch = 8'h02;
        wait_tick(40, n);
        wait_tick(40, n);
        check("period_r2_a", n, 12);
        wait_tick(40, n);
        check("period_r2_b", n, 12);

        // ---------------- pause/resume keeps phase ----------------
        wait_tick(40, n);
        check("phase_sync_tick", n, 12);
        btn1   = 1'b0;
        cnt    = 1;
        tick_j = -1;
        done   = 1'b0;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (!done) begin
                if (tick === 1'b1) begin
                    tick_j = j;
                    done   = 1'b1;
                end else if (state === 2'd1) begin
                    cnt++;
                end
            end
            if (j == 15) check("paused_state", int'(state), 2);
            if (j == 4)  btn1 = 1'b1;
            if (j == 20) btn1 = 1'b0;
            if (j == 24) btn1 = 1'b1;
        end
        check("resume_tick_cycle", tick_j, 32);
        check("run_cycles_between_ticks", cnt, 12);

        // ---------------- long press: one clr ----------------
        btn1       = 1'b0;
        clr_n      = 0;
        clr_j      = -1;
        late_ticks = 0;
        for (int j = 1; j <= 60; j++) begin
            @(negedge clk);
            if (clr === 1'b1) begin
                clr_n++;
                clr_j = j;
                check("state_at_clr", int'(state), 0);
            end
            if (j >= 25 && tick === 1'b1) late_ticks++;
            if (j == 40) btn1 = 1'b1;
        end
        check("clr_pulses", clr_n, 1);
        check("clr_cycle", clr_j, 25);
        check("ticks_after_long", late_ticks, 0);
        check("state_after_long", int'(state), 0);

        // ---------------- async reset mid-RUN ----------------
        switch = 8'h82;
        short_press();
        wait_state(2'd1, 20, n);
        check("rst_seq_run", n, 5);
        repeat (5) @(negedge clk);
        check("dir_before_rst", int'(dir), 1);
        #2 rst = 1'b0;
        #1;
        check("rst_tick", int'(tick), 0);
        check("rst_clr", int'(clr), 0);
        check("rst_state", int'(state), 0);
        check("rst_dir", int'(dir), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_state", int'(state), 0);
        short_press();
        wait_state(2'd1, 20, n);
        check("post_rst_run", n, 5);
        wait_tick(40, n);
        check("post_rst_first_tick", n, 12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
